// File: rtl/rsp_unpack.sv
// rsp_unpack: splits 128-bit response lines into 32-bit beats, single word or wrapped 4-word burst per queued descriptor.
module rsp_unpack #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         info_valid,
  output logic         info_rdy,
  input  logic         info_burst,
  input  logic [1:0]   info_word,
  input  logic         rsp_valid,
  output logic         rsp_rdy,
  input  logic [127:0] rsp_data,
  output logic         out_valid,
  input  logic         out_rdy,
  output logic [31:0]  out_data,
  output logic         out_last
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [AW:0] count;
  logic [AW-1:0] wp, rp;
  logic [2:0] q [DEPTH];
  logic [127:0] line;
  logic [1:0] ptr, rem;
  logic push, accept, beat;
  always_comb begin
    info_rdy = count != (AW+1)'(DEPTH);
    push = info_valid && info_rdy;
    out_valid = state == SEND;
    out_last = out_valid && rem == 2'd0;
    out_data = out_valid ? line[32*ptr +: 32] : 32'd0;
    beat = out_valid && out_rdy;
    // out_rdy feeds rsp_rdy combinationally so lines can follow each other without a bubble
    rsp_rdy = count != '0 && (state == IDLE || (beat && out_last));
    accept = rsp_valid && rsp_rdy;
    state_nx = accept ? SEND : (beat && out_last) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (push) q[wp] <= {info_burst, info_word};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      count <= '0;
      wp <= '0;
      rp <= '0;
      line <= '0;
      ptr <= '0;
      rem <= '0;
    end else begin
      state <= state_nx;
      count <= count + (AW+1)'(push) - (AW+1)'(accept);
      if (push) wp <= wp + 1'b1;
      if (accept) begin
        rp <= rp + 1'b1;
        line <= rsp_data;
        ptr <= q[rp][1:0];
        rem <= q[rp][2] ? 2'd3 : 2'd0;
      end else if (beat && !out_last) begin
        ptr <= ptr + 2'd1;
        rem <= rem - 2'd1;
      end
    end
endmodule

// File: tb/tb_rsp_unpack.sv
// tb_rsp_unpack: directed and random stimulus checked against a transaction-level beat model.
module tb_rsp_unpack;
  logic clk = 0, rstn = 0;
  logic info_valid = 0, info_rdy, info_burst = 0;
  logic [1:0] info_word = 0;
  logic rsp_valid = 0, rsp_rdy;
  logic [127:0] rsp_data = 0;
  logic out_valid, out_rdy = 0, out_last;
  logic [31:0] out_data;
  logic [31:0] pend[$];
  logic [2:0] dq[$];
  int tests = 0, fails = 0;
  localparam logic [127:0] L = 128'h44444444_33333333_22222222_11111111;
  rsp_unpack #(.DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .info_valid(info_valid), .info_rdy(info_rdy), .info_burst(info_burst), .info_word(info_word),
    .rsp_valid(rsp_valid), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic iv, input logic ib, input logic [1:0] iw,
                      input logic rv, input logic [127:0] rd, input logic ordy);
    logic e_ir, e_rr, psh, acc, bt;
    logic [2:0] d;
    @(negedge clk);
    info_valid = iv; info_burst = ib; info_word = iw;
    rsp_valid = rv; rsp_data = rd; out_rdy = ordy;
    #1;
    e_ir = dq.size() < 4;
    bt = pend.size() > 0 && ordy;
    e_rr = dq.size() > 0 && (pend.size() == 0 || (bt && pend.size() == 1));
    chk("info_rdy", info_rdy, e_ir);
    chk("rsp_rdy", rsp_rdy, e_rr);
    chk("out_valid", out_valid, pend.size() > 0);
    chk("out_last", out_last, pend.size() == 1);
    if (pend.size() > 0) chk("out_data", out_data, pend[0]);
    psh = iv && e_ir;
    acc = rv && e_rr;
    @(posedge clk);
    if (bt) void'(pend.pop_front());
    if (acc) begin
      d = dq.pop_front();
      for (int i = 0; i < (d[2] ? 4 : 1); i++)
        pend.push_back(rd[32*((int'(d[1:0]) + i) % 4) +: 32]);
    end
    if (psh) dq.push_back({ib, iw});
  endtask
  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    pend.delete();
    dq.delete();
    info_valid = 0; rsp_valid = 0; out_rdy = 0;
    @(negedge clk);
    chk("rst_info_rdy", info_rdy, 1);
    chk("rst_rsp_rdy", rsp_rdy, 0);
    rstn = 1;
  endtask
  initial begin
    logic [1:0] pat [7];
    pat = '{1, 0, 0, 1, 0, 1, 1};
    do_reset();
    // single word
    step(1, 0, 2, 0, 0, 1);
    step(0, 0, 0, 1, L, 1);
    #1 chk("single_data", out_data, 32'h33333333);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // wrapped burst
    step(1, 1, 2, 0, 0, 1);
    step(0, 0, 0, 1, L, 1);
    repeat (5) step(0, 0, 0, 0, 0, 1);
    // back-to-back
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 3, 0, 0, 1);
    repeat (6) step(0, 0, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 1);
    step(0, 0, 0, 0, 0, 1);
    // backpressure
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, L, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, pat[i][0]);
    step(0, 0, 0, 0, 0, 1);
    // empty queue, then fill
    repeat (12) step(0, 0, 0, 1, L, 1);
    repeat (5) step(1, 1, 3, 0, 0, 1);
    #1 chk("full_info_rdy", info_rdy, 0);
    // reset mid-burst
    do_reset();
    step(1, 1, 1, 0, 0, 1);
    step(0, 0, 0, 1, L, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    do_reset();
    repeat (3) step(0, 0, 0, 1, L, 1);
    // random
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1), 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 3) != 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
